// File: rtl/qpsk_dibit_framer.sv
// Purpose : frames a payload byte stream for the QPSK mapper. It prepends an alternating preamble
//           and sends each byte as four dibits, MSB first. Optional CRC-8 trailer: define QPSK_DIBIT_FRAMER_CRC_EN.
// Latency : the first preamble strobe appears SYM_DIV+1 edges after the byte is accepted from IDLE.
// Backpressure: single-byte holding buffer, in_ready = !buf_full. A missed payload slot pulses underrun_o.
module qpsk_dibit_framer #(
  parameter int SYM_DIV = 4,
  parameter int PRE_LEN = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic       valid_o,
  output logic [1:0] data_o,
  output logic       sof_o,
  output logic       eof_o,
  output logic       busy_o,
  output logic       underrun_o
);

  localparam int CW = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;
  localparam int PW = (PRE_LEN > 1) ? $clog2(PRE_LEN) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SYM_DIV - 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(PRE_LEN - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PRE  = 2'd1;
  localparam logic [1:0] S_PAY  = 2'd2;
`ifdef QPSK_DIBIT_FRAMER_CRC_EN
  localparam logic [1:0] S_CRC  = 2'd3;
`endif

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [PW-1:0] pidx;
  logic [1:0]    didx;
  logic [7:0]    buf_dat;
  logic          buf_last;
  logic          buf_full;
  logic [7:0]    sr;
  logic          sr_last;
  logic          tick;
  logic          accept;
  logic          load;

`ifdef QPSK_DIBIT_FRAMER_CRC_EN
  logic [7:0] crc;

  // Bytewise CRC-8, polynomial 0x07, MSB first
  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    end
    return r;
  endfunction
`endif

  assign tick     = (cnt == CNT_MAX);
  assign in_ready = RST & ~buf_full;
  assign accept   = in_valid & in_ready;
  assign load     = (state == S_PAY) & tick & (didx == 2'd0) & buf_full;

  // Holding buffer: filled by the handshake and drained when the FSM loads the shift register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      buf_full <= 1'b0;
      buf_dat  <= 8'h00;
      buf_last <= 1'b0;
    end else if (accept) begin
      buf_full <= 1'b1;
      buf_dat  <= in_data;
      buf_last <= in_last;
    end else if (load) begin
      buf_full <= 1'b0;
    end
  end

  // Framing FSM: symbol timer, preamble/payload/trailer sequencing and registered output strobes
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= S_IDLE;
      cnt        <= '0;
      pidx       <= '0;
      didx       <= 2'd0;
      sr         <= 8'h00;
      sr_last    <= 1'b0;
      valid_o    <= 1'b0;
      data_o     <= 2'b00;
      sof_o      <= 1'b0;
      eof_o      <= 1'b0;
      busy_o     <= 1'b0;
      underrun_o <= 1'b0;
`ifdef QPSK_DIBIT_FRAMER_CRC_EN
      crc        <= 8'h00;
`endif
    end else begin
      valid_o    <= 1'b0;
      sof_o      <= 1'b0;
      eof_o      <= 1'b0;
      underrun_o <= 1'b0;
      busy_o     <= (state != S_IDLE);
      if (state == S_IDLE) cnt <= '0;
      else                 cnt <= tick ? '0 : cnt + CW'(1);
      case (state)
        S_IDLE: begin
          if (buf_full) begin
            state <= S_PRE;
            pidx  <= '0;
`ifdef QPSK_DIBIT_FRAMER_CRC_EN
            crc   <= 8'h00;
`endif
          end
        end
        S_PRE: begin
          if (tick) begin
            valid_o <= 1'b1;
            data_o  <= pidx[0] ? 2'b11 : 2'b00;
            sof_o   <= (pidx == '0);
            if (pidx == PRE_MAX) begin
              state <= S_PAY;
              didx  <= 2'd0;
            end else begin
              pidx <= pidx + PW'(1);
            end
          end
        end
        S_PAY: begin
          if (tick) begin
            if (didx == 2'd0) begin
              if (buf_full) begin
                valid_o <= 1'b1;
                data_o  <= buf_dat[7:6];
                sr      <= {buf_dat[5:0], 2'b00};
                sr_last <= buf_last;
                didx    <= 2'd1;
`ifdef QPSK_DIBIT_FRAMER_CRC_EN
                crc     <= crc8_byte(crc, buf_dat);
`endif
              end else begin
                underrun_o <= 1'b1;
              end
            end else begin
              valid_o <= 1'b1;
              data_o  <= sr[7:6];
              sr      <= {sr[5:0], 2'b00};
              didx    <= didx + 2'd1;
              if (didx == 2'd3 && sr_last) begin
`ifdef QPSK_DIBIT_FRAMER_CRC_EN
                state <= S_CRC;
                sr    <= crc;
`else
                state <= S_IDLE;
                eof_o <= 1'b1;
`endif
              end
            end
          end
        end
`ifdef QPSK_DIBIT_FRAMER_CRC_EN
        S_CRC: begin
          if (tick) begin
            valid_o <= 1'b1;
            data_o  <= sr[7:6];
            sr      <= {sr[5:0], 2'b00};
            didx    <= didx + 2'd1;
            if (didx == 2'd3) begin
              state <= S_IDLE;
              eof_o <= 1'b1;
            end
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qpsk_dibit_framer.sv
// Purpose : directed bench for qpsk_dibit_framer. It uses two instances: SYM_DIV=2/PRE_LEN=4 and SYM_DIV=1/PRE_LEN=1.
// Latency : checks the first-strobe latency, the strobe spacing, the dibit order, the sof/eof/busy timing and the underrun slots.
// Backpressure: checks that in_ready stays low while the buffer is full, during reset, and across withheld bytes.
module tb_qpsk_dibit_framer;

  typedef struct {
    logic [7:0] din;
    logic       last;
    logic [1:0] d0, d1, d2, d3;
    logic [1:0] c0, c1, c2, c3;
  } vec_t;

  typedef struct {
    logic [1:0] dib;
    logic       sof;
    logic       eof;
  } exp_t;

  typedef struct {
    logic [1:0] dib;
    logic       sof;
    logic       eof;
    int         cyc;
  } cap_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       sel = 1'b0;

  logic       rdy_a, va, sa, ea, ba, ua;
  logic       rdy_b, vb, sb, eb, bb, ub;
  logic [1:0] da, db;
  logic       m_rdy, m_valid, m_sof, m_eof, m_busy, m_und;
  logic [1:0] m_data;

  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  int   und_cnt = 0;
  int   acc_cyc = 0;
  int   first_acc = 0;
  int   sd = 2;
  int   pl = 4;
  vec_t vecs[5];
  exp_t exp_q[$];
  cap_t cap[$];

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  qpsk_dibit_framer #(.SYM_DIV(2), .PRE_LEN(4)) dut_a (
    .CLK(CLK), .RST(RST), .in_valid(in_valid & ~sel), .in_data(in_data), .in_last(in_last),
    .in_ready(rdy_a), .valid_o(va), .data_o(da), .sof_o(sa), .eof_o(ea), .busy_o(ba), .underrun_o(ua)
  );

  qpsk_dibit_framer #(.SYM_DIV(1), .PRE_LEN(1)) dut_b (
    .CLK(CLK), .RST(RST), .in_valid(in_valid & sel), .in_data(in_data), .in_last(in_last),
    .in_ready(rdy_b), .valid_o(vb), .data_o(db), .sof_o(sb), .eof_o(eb), .busy_o(bb), .underrun_o(ub)
  );

  assign m_rdy   = sel ? rdy_b : rdy_a;
  assign m_valid = sel ? vb : va;
  assign m_data  = sel ? db : da;
  assign m_sof   = sel ? sb : sa;
  assign m_eof   = sel ? eb : ea;
  assign m_busy  = sel ? bb : ba;
  assign m_und   = sel ? ub : ua;

  // Capture every strobe of the selected instance away from the active edge
  always @(negedge CLK) begin
    if (m_valid) cap.push_back('{m_data, m_sof, m_eof, cyc});
    if (m_und) und_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, input logic keep);
    logic ok;
    ok = 1'b0;
    in_data  = b;
    in_last  = last;
    in_valid = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if (m_rdy) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    check("accept_ready", ok, 1);
    @(posedge CLK);
    #1;
    acc_cyc = cyc;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_eof();
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(negedge CLK);
      if (m_eof) begin
        ok = 1'b1;
        break;
      end
    end
    check("eof_seen", ok, 1);
    if (ok) begin
      check("busy_at_eof", m_busy, 1);
      @(negedge CLK);
      check("busy_drop", m_busy, 0);
    end
    @(negedge CLK);
  endtask

  task automatic build(input int lo, input int hi);
    exp_q.delete();
    for (int p = 0; p < pl; p++) exp_q.push_back('{(p % 2) ? 2'b11 : 2'b00, p == 0, 1'b0});
    for (int v = lo; v <= hi; v++) begin
      exp_q.push_back('{vecs[v].d0, 1'b0, 1'b0});
      exp_q.push_back('{vecs[v].d1, 1'b0, 1'b0});
      exp_q.push_back('{vecs[v].d2, 1'b0, 1'b0});
      exp_q.push_back('{vecs[v].d3, 1'b0, 1'b0});
`ifdef QPSK_DIBIT_FRAMER_CRC_EN
      if (vecs[v].last) begin
        exp_q.push_back('{vecs[v].c0, 1'b0, 1'b0});
        exp_q.push_back('{vecs[v].c1, 1'b0, 1'b0});
        exp_q.push_back('{vecs[v].c2, 1'b0, 1'b0});
        exp_q.push_back('{vecs[v].c3, 1'b0, 1'b0});
      end
`endif
    end
    exp_q[exp_q.size() - 1].eof = 1'b1;
  endtask

  // Compare the captured strobes with exp_q; gi/gv name one slot whose spacing differs from sd
  task automatic cmp(input int gi, input int gv);
    int n;
    check("n_dibits", cap.size(), exp_q.size());
    n = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("dibit[%0d]", i), cap[i].dib, exp_q[i].dib);
      check($sformatf("sof[%0d]", i), cap[i].sof, exp_q[i].sof);
      check($sformatf("eof[%0d]", i), cap[i].eof, exp_q[i].eof);
      if (i > 0) check($sformatf("spacing[%0d]", i), cap[i].cyc - cap[i-1].cyc, (i == gi) ? gv : sd);
    end
    if (n > 0) check("latency", cap[0].cyc - first_acc, sd + 1);
  endtask

  initial begin
    int eofs;
    int n;
    // byte, last, payload dibits MSB first, CRC dibits (used only for last bytes)
    vecs[0] = '{8'hB4, 1'b1, 2'd2, 2'd3, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
    vecs[1] = '{8'h12, 1'b0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0};
    vecs[2] = '{8'hFF, 1'b1, 2'd3, 2'd3, 2'd3, 2'd3, 2'd2, 2'd0, 2'd3, 2'd2};
    vecs[3] = '{8'h3C, 1'b0, 2'd0, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    vecs[4] = '{8'hC3, 1'b1, 2'd3, 2'd0, 2'd0, 2'd3, 2'd1, 2'd0, 2'd0, 2'd2};

    // Reset state
    #12;
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_sof", m_sof, 0);
    check("rst_eof", m_eof, 0);
    check("rst_busy", m_busy, 0);
    check("rst_underrun", m_und, 0);
    check("rst_in_ready", m_rdy, 0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("idle_in_ready", m_rdy, 1);

    // Single-byte frame
    cap.delete();
    send_byte(vecs[0].din, vecs[0].last, 1'b0);
    first_acc = acc_cyc;
    wait_eof();
    build(0, 0);
    cmp(-1, 0);

    // Two bytes with in_valid held high: the second waits while the first sits in the buffer
    cap.delete();
    und_cnt = 0;
    send_byte(vecs[1].din, vecs[1].last, 1'b1);
    first_acc = acc_cyc;
    @(negedge CLK);
    check("ready_low_while_full", m_rdy, 0);
    send_byte(vecs[2].din, vecs[2].last, 1'b0);
    wait_eof();
    build(1, 2);
    cmp(-1, 0);
    check("no_underrun", und_cnt, 0);

    // Second byte withheld for three payload slots
    cap.delete();
    und_cnt = 0;
    send_byte(vecs[3].din, vecs[3].last, 1'b0);
    first_acc = acc_cyc;
    n = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge CLK);
      if (m_und) n++;
      if (n == 3) break;
    end
    check("underrun_pulses_seen", n, 3);
    send_byte(vecs[4].din, vecs[4].last, 1'b0);
    wait_eof();
    build(3, 4);
    cmp(pl + 4, 4 * sd);
    check("underrun_count", und_cnt, 3);

    // Reset in mid-payload aborts the frame
    cap.delete();
    send_byte(8'h81, 1'b0, 1'b0);
    first_acc = acc_cyc;
    for (int k = 0; k < 300; k++) begin
      @(negedge CLK);
      if (cap.size() >= pl + 2) break;
    end
    check("reached_payload", int'(cap.size() >= pl + 2), 1);
    @(posedge CLK);
    #2 RST = 1'b0;
    #1;
    check("abort_valid", m_valid, 0);
    check("abort_data", m_data, 0);
    check("abort_sof", m_sof, 0);
    check("abort_eof", m_eof, 0);
    check("abort_busy", m_busy, 0);
    check("abort_underrun", m_und, 0);
    check("abort_in_ready", m_rdy, 0);
    eofs = 0;
    foreach (cap[i]) if (cap[i].eof) eofs++;
    check("abort_no_eof", eofs, 0);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    #1;
    check("release_in_ready", m_rdy, 1);
    @(negedge CLK);
    check("release_busy", m_busy, 0);
    check("release_valid", m_valid, 0);
    cap.delete();
    send_byte(vecs[0].din, vecs[0].last, 1'b0);
    first_acc = acc_cyc;
    wait_eof();
    build(0, 0);
    cmp(-1, 0);

    // SYM_DIV=1, PRE_LEN=1: back-to-back strobes, latency of two edges
    sel = 1'b1;
    sd  = 1;
    pl  = 1;
    @(negedge CLK);
    cap.delete();
    send_byte(vecs[0].din, vecs[0].last, 1'b0);
    first_acc = acc_cyc;
    wait_eof();
    build(0, 0);
    cmp(-1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
